// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared constants, types and helpers for the multi-port
//                register file: address-width helper, default parameter
//                values and the write-port priority resolver.
//  Revision    : 1.0  initial release
// ============================================================================
package regfile_pkg;

    localparam int C_DEF_DATA_W   = 16;
    localparam int C_DEF_NUM_REGS = 8;
    localparam int C_DEF_NUM_RD   = 3;
    localparam int C_DEF_NUM_WR   = 2;

    // Resolver works on fixed maximum widths so one function serves every
    // parametrisation; callers zero-pad unused ports and address bits.
    localparam int C_MAX_WR = 4;
    localparam int C_MAX_AW = 8;

    typedef struct packed {
        logic       hit;   // at least one enabled port targets the address
        logic [1:0] port;  // winning (highest-index) port
    } wr_sel_t;

    function automatic int addr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Later iterations overwrite earlier ones, so the highest index wins.
    function automatic wr_sel_t resolve_wr(
        input logic [C_MAX_WR-1:0]               en,
        input logic [C_MAX_WR-1:0][C_MAX_AW-1:0] addrs,
        input logic [C_MAX_AW-1:0]               addr
    );
        wr_sel_t sel;
        sel = '0;
        for (int j = 0; j < C_MAX_WR; j++) begin
            if (en[j] && (addrs[j] == addr)) begin
                sel.hit  = 1'b1;
                sel.port = 2'(j);
            end
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : Per-register busy (pending producer) tracking. Allocation
//                sets a bit, a write clears it, allocation wins on a tie.
//                rd_busy optionally hides a bit being cleared this cycle.
//  Ports       : clk, rst            - clock / synchronous active-high reset
//                alloc_en/alloc_addr - qualified allocation request
//                wr_hit              - per-register qualified write this cycle
//                rd_addr             - packed read addresses
//                busy                - registered busy vector
//                rd_busy             - busy bit per read port (combinational)
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_scoreboard #(
    parameter int NUM_REGS = 8,
    parameter int NUM_RD   = 3,
    parameter int BYPASS   = 1,
    parameter int AW       = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_en,
    input  logic [AW-1:0]        alloc_addr,
    input  logic [NUM_REGS-1:0]  wr_hit,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_REGS-1:0]  busy,
    output logic [NUM_RD-1:0]    rd_busy
);

    logic [NUM_REGS-1:0] r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (alloc_en && (alloc_addr == AW'(k))) begin
                    r_busy[k] <= 1'b1;
                end else if (wr_hit[k]) begin
                    r_busy[k] <= 1'b0;
                end
            end
        end
    end

    assign busy = r_busy;

    generate
        for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_busy
            logic [AW-1:0] w_ra;
            logic          w_fwd_clear;
            assign w_ra        = rd_addr[i*AW +: AW];
            // Forward the clear only when no new producer claims it this cycle.
            assign w_fwd_clear = (BYPASS != 0) && wr_hit[w_ra] &&
                                 !(alloc_en && (alloc_addr == w_ra));
            assign rd_busy[i]  = r_busy[w_ra] & ~w_fwd_clear;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp
//  Description : Parametrised multi-port register file with write priority
//                (highest port wins), optional write-to-read bypass,
//                optional hardwired zero register and busy scoreboard.
//  Ports       : clk, rst               - clock / sync active-high reset
//                rd_addr -> rd_data    - combinational read ports
//                rd_busy               - busy bit of each read address
//                wr_en/wr_addr/wr_data - write ports
//                alloc_en/alloc_addr   - mark register pending
//                busy                  - registered busy vector
//                wr_conflict           - pulse: same-address write collision
//  Revision    : 1.0  initial release
// ============================================================================
import regfile_pkg::*;

module regfile_mp #(
    parameter  int DATA_W   = C_DEF_DATA_W,
    parameter  int NUM_REGS = C_DEF_NUM_REGS,
    parameter  int NUM_RD   = C_DEF_NUM_RD,
    parameter  int NUM_WR   = C_DEF_NUM_WR,
    parameter  int BYPASS   = 1,
    parameter  int ZERO_REG = 0,
    localparam int AW       = addr_width(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     alloc_en,
    input  logic [AW-1:0]            alloc_addr,
    output logic [NUM_REGS-1:0]      busy,
    output logic                     wr_conflict
);

    logic [DATA_W-1:0]                 r_mem [NUM_REGS];
    logic                              r_conflict;

    logic [C_MAX_WR-1:0]               w_wen;
    logic [C_MAX_WR-1:0][C_MAX_AW-1:0] w_waddr;
    logic [DATA_W-1:0]                 w_wdata [C_MAX_WR];
    wr_sel_t                           w_reg_sel [NUM_REGS];
    logic [NUM_REGS-1:0]               w_wr_hit;
    logic                              w_alloc_en;
    logic                              w_conflict;

    // Qualify write ports: reset suppresses everything (bypass included) and
    // writes to a hardwired zero register vanish before any other logic.
    generate
        for (genvar j = 0; j < C_MAX_WR; j++) begin : g_wr_port
            if (j < NUM_WR) begin : g_used
                assign w_waddr[j] = C_MAX_AW'(wr_addr[j*AW +: AW]);
                assign w_wdata[j] = wr_data[j*DATA_W +: DATA_W];
                assign w_wen[j]   = wr_en[j] & ~rst &
                                    ~((ZERO_REG != 0) && (wr_addr[j*AW +: AW] == '0));
            end else begin : g_unused
                assign w_waddr[j] = '0;
                assign w_wdata[j] = '0;
                assign w_wen[j]   = 1'b0;
            end
        end
    endgenerate

    assign w_alloc_en = alloc_en & ~rst &
                        ~((ZERO_REG != 0) && (alloc_addr == '0));

    always_comb begin
        w_conflict = 1'b0;
        for (int j = 0; j < C_MAX_WR; j++) begin
            for (int k = j + 1; k < C_MAX_WR; k++) begin
                if (w_wen[j] && w_wen[k] && (w_waddr[j] == w_waddr[k])) begin
                    w_conflict = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_conflict <= 1'b0;
        end else begin
            r_conflict <= w_conflict;
        end
    end

    assign wr_conflict = r_conflict;

    // One resolver per register feeds both the storage update and the read
    // bypass, so both always agree on which port won.
    generate
        for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
            localparam logic [C_MAX_AW-1:0] C_IDX = C_MAX_AW'(k);
            assign w_reg_sel[k] = resolve_wr(w_wen, w_waddr, C_IDX);
            assign w_wr_hit[k]  = w_reg_sel[k].hit;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_mem[k] <= '0;
                end else if (w_reg_sel[k].hit) begin
                    r_mem[k] <= w_wdata[w_reg_sel[k].port];
                end
            end
        end
    endgenerate

    generate
        for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
            logic [AW-1:0]     w_ra;
            wr_sel_t           w_sel;
            logic [DATA_W-1:0] w_rd;

            assign w_ra  = rd_addr[i*AW +: AW];
            assign w_sel = w_reg_sel[w_ra];

            always_comb begin
                w_rd = r_mem[w_ra];
                if ((BYPASS != 0) && w_sel.hit) begin
                    w_rd = w_wdata[w_sel.port];
                end
                if ((ZERO_REG != 0) && (w_ra == '0)) begin
                    w_rd = '0;
                end
            end

            assign rd_data[i*DATA_W +: DATA_W] = w_rd;
        end
    endgenerate

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .BYPASS   (BYPASS),
        .AW       (AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .alloc_en   (w_alloc_en),
        .alloc_addr (alloc_addr),
        .wr_hit     (w_wr_hit),
        .rd_addr    (rd_addr),
        .busy       (busy),
        .rd_busy    (rd_busy)
    );

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_mp
//  Description : Directed self-checking bench. Instance A uses the default
//                configuration (bypass on), B shares A's inputs with bypass
//                off and a hardwired zero register, C is a 32-bit, 32-entry,
//                4-read / 3-write configuration.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;

    // Shared stimulus for A and B
    logic [8:0]  rd_addr;
    logic [1:0]  wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        alloc_en;
    logic [2:0]  alloc_addr;

    logic [47:0] a_rd_data, b_rd_data;
    logic [2:0]  a_rd_busy, b_rd_busy;
    logic [7:0]  a_busy, b_busy;
    logic        a_conf, b_conf;

    // Stimulus for C
    logic [19:0]  c_rd_addr;
    logic [2:0]   c_wr_en;
    logic [14:0]  c_wr_addr;
    logic [95:0]  c_wr_data;
    logic         c_alloc_en;
    logic [4:0]   c_alloc_addr;
    logic [127:0] c_rd_data;
    logic [3:0]   c_rd_busy;
    logic [31:0]  c_busy;
    logic         c_conf;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(3), .NUM_WR(2),
                 .BYPASS(1), .ZERO_REG(0)) u_a (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(a_rd_data),
        .rd_busy(a_rd_busy), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .busy(a_busy), .wr_conflict(a_conf)
    );

    regfile_mp #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(3), .NUM_WR(2),
                 .BYPASS(0), .ZERO_REG(1)) u_b (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(b_rd_data),
        .rd_busy(b_rd_busy), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .busy(b_busy), .wr_conflict(b_conf)
    );

    regfile_mp #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(4), .NUM_WR(3),
                 .BYPASS(1), .ZERO_REG(0)) u_c (
        .clk(clk), .rst(rst), .rd_addr(c_rd_addr), .rd_data(c_rd_data),
        .rd_busy(c_rd_busy), .wr_en(c_wr_en), .wr_addr(c_wr_addr),
        .wr_data(c_wr_data), .alloc_en(c_alloc_en), .alloc_addr(c_alloc_addr),
        .busy(c_busy), .wr_conflict(c_conf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        alloc_en = 1'b0; alloc_addr = '0;
        c_rd_addr = '0; c_wr_en = '0; c_wr_addr = '0; c_wr_data = '0;
        c_alloc_en = 1'b0; c_alloc_addr = '0;
        tick();
        rst = 1'b0;

        // Preload r3 = 1234 through port 0
        wr_en = 2'b01; wr_addr = {3'd0, 3'd3}; wr_data = {16'h0, 16'h1234};
        rd_addr = {3'd0, 3'd0, 3'd3};
        tick();
        wr_en = 2'b00;
        #1;
        chk("preload_a", a_rd_data[15:0], 16'h1234);
        chk("preload_b", b_rd_data[15:0], 16'h1234);

        // Reset clears storage and status
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_rd_a", a_rd_data, 48'h0);
        chk("rst_rd_b", b_rd_data, 48'h0);
        chk("rst_busy_a", a_busy, 8'h00);
        chk("rst_conf_a", a_conf, 1'b0);
        chk("rst_rdbusy_a", a_rd_busy, 3'b000);

        // Both ports write r5: port 1 wins
        wr_en = 2'b11; wr_addr = {3'd5, 3'd5}; wr_data = {16'h5555, 16'hAAAA};
        rd_addr = {3'd0, 3'd0, 3'd5};
        #1;
        chk("prio_byp_a", a_rd_data[15:0], 16'h5555);
        chk("prio_nobyp_b", b_rd_data[15:0], 16'h0000);
        tick();
        wr_en = 2'b00;
        #1;
        chk("prio_a", a_rd_data[15:0], 16'h5555);
        chk("prio_b", b_rd_data[15:0], 16'h5555);
        chk("conf_a", a_conf, 1'b1);
        chk("conf_b", b_conf, 1'b1);
        tick();
        chk("conf_drop_a", a_conf, 1'b0);

        // Bypass vs. no bypass on r2
        wr_en = 2'b10; wr_addr = {3'd2, 3'd0}; wr_data = {16'hBEEF, 16'h0};
        rd_addr = {3'd0, 3'd0, 3'd2};
        #1;
        chk("byp_a", a_rd_data[15:0], 16'hBEEF);
        chk("nobyp_b", b_rd_data[15:0], 16'h0000);
        tick();
        wr_en = 2'b00;
        #1;
        chk("late_b", b_rd_data[15:0], 16'hBEEF);
        chk("noconf_a", a_conf, 1'b0);

        // Scoreboard: allocate r4
        alloc_en = 1'b1; alloc_addr = 3'd4; rd_addr = {3'd0, 3'd4, 3'd0};
        tick();
        alloc_en = 1'b0;
        #1;
        chk("alloc_busy_a", a_busy, 8'h10);
        chk("alloc_busy_b", b_busy, 8'h10);
        chk("alloc_rdbusy_a", a_rd_busy[1], 1'b1);

        // Write + alloc on r4: alloc wins
        wr_en = 2'b01; wr_addr = {3'd0, 3'd4}; wr_data = {16'h0, 16'h4444};
        alloc_en = 1'b1; alloc_addr = 3'd4;
        #1;
        chk("wa_rdbusy_a", a_rd_busy[1], 1'b1);
        tick();
        wr_en = 2'b00; alloc_en = 1'b0;
        #1;
        chk("wa_busy_a", a_busy, 8'h10);
        chk("wa_data_a", a_rd_data[31:16], 16'h4444);

        // Plain write on r4 clears busy; bypass hides it this cycle
        wr_en = 2'b01; wr_addr = {3'd0, 3'd4}; wr_data = {16'h0, 16'h4445};
        #1;
        chk("clr_rdbusy_a", a_rd_busy[1], 1'b0);
        chk("clr_rdbusy_b", b_rd_busy[1], 1'b1);
        tick();
        wr_en = 2'b00;
        #1;
        chk("clr_busy_a", a_busy, 8'h00);
        chk("clr_busy_b", b_busy, 8'h00);

        // Zero register on B; A stores it normally
        wr_en = 2'b11; wr_addr = {3'd0, 3'd0}; wr_data = {16'hFFFF, 16'hFFFF};
        alloc_en = 1'b1; alloc_addr = 3'd0; rd_addr = {3'd0, 3'd0, 3'd0};
        #1;
        chk("zr_same_b", b_rd_data[47:32], 16'h0000);
        chk("zr_byp_a", a_rd_data[47:32], 16'hFFFF);
        chk("zr_rdbusy_b", b_rd_busy[2], 1'b0);
        tick();
        wr_en = 2'b00; alloc_en = 1'b0;
        #1;
        chk("zr_rd_b", b_rd_data[47:32], 16'h0000);
        chk("zr_busy_b", b_busy, 8'h00);
        chk("zr_conf_b", b_conf, 1'b0);
        chk("zr_conf_a", a_conf, 1'b1);
        chk("zr_busy_a", a_busy, 8'h01);
        chk("zr_rd_a", a_rd_data[47:32], 16'hFFFF);

        // Write during reset is ignored, including bypass
        rst = 1'b1; wr_en = 2'b01; wr_addr = {3'd0, 3'd6}; wr_data = {16'h0, 16'h6666};
        rd_addr = {3'd0, 3'd0, 3'd6};
        #1;
        chk("rstw_byp_a", a_rd_data[15:0], 16'h0000);
        tick();
        rst = 1'b0; wr_en = 2'b00; rd_addr = {3'd0, 3'd0, 3'd6};
        #1;
        chk("rstw_rd_a", a_rd_data[15:0], 16'h0000);
        chk("rstw_busy_a", a_busy, 8'h00);
        chk("rstw_conf_a", a_conf, 1'b0);

        // Wide configuration: ports 0,1 hit r7, port 2 hits r9, alloc r9
        c_wr_en = 3'b111;
        c_wr_addr = {5'd9, 5'd7, 5'd7};
        c_wr_data = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        c_alloc_en = 1'b1; c_alloc_addr = 5'd9;
        c_rd_addr = {5'd9, 5'd31, 5'd9, 5'd7};
        #1;
        chk("c_byp0", c_rd_data[31:0], 32'h2222_2222);
        chk("c_byp1", c_rd_data[63:32], 32'h3333_3333);
        chk("c_rdbusy_alloc", c_rd_busy[1], 1'b0);
        tick();
        c_wr_en = 3'b000; c_alloc_en = 1'b0;
        #1;
        chk("c_busy", c_busy, 32'h0000_0200);
        chk("c_conf", c_conf, 1'b1);
        chk("c_rd0", c_rd_data[31:0], 32'h2222_2222);
        chk("c_rdbusy", c_rd_busy, 4'b1010);

        // Ports 0 and 2 on r31: port 2 wins
        c_wr_en = 3'b101;
        c_wr_addr = {5'd31, 5'd3, 5'd31};
        c_wr_data = {32'h0000_00C0, 32'h0, 32'h0000_00A0};
        #1;
        chk("c_prio_byp", c_rd_data[95:64], 32'h0000_00C0);
        tick();
        c_wr_en = 3'b000;
        #1;
        chk("c_prio", c_rd_data[95:64], 32'h0000_00C0);
        chk("c_conf2", c_conf, 1'b1);

        // Write r9 alone clears its busy bit
        c_wr_en = 3'b010; c_wr_addr = {5'd0, 5'd9, 5'd0};
        c_wr_data = {32'h0, 32'h0000_0099, 32'h0};
        #1;
        chk("c_clr_rdbusy", c_rd_busy[1], 1'b0);
        tick();
        c_wr_en = 3'b000;
        #1;
        chk("c_clr_busy", c_busy, 32'h0);
        chk("c_clr_rd", c_rd_data[63:32], 32'h0000_0099);
        chk("c_conf3", c_conf, 1'b0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
